clk_div: RTL

Programmable integer clock divider sitting directly downstream of the 4-to-1 PLL clock mux in the CRG. It runs on the selected PLL clock and produces a divided clock with a registered, glitch-free output. A valid/ready handshake accepts new ratios, which take effect only at a period boundary, so the output never shows a runt pulse.

---
 rtl/crg_pkg.sv | 34 +++
 rtl/clk_div_cnt.sv | 37 +++
 rtl/clk_div.sv | 107 ++++++++++
 3 files changed

// File: rtl/crg_pkg.sv
// Shared CRG types, constants and helpers for the programmable clock dividers.
package crg_pkg;

  // Ratio-update state of a divider: free-running, or holding a ratio
  // until the next period boundary.
  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } clk_div_state_e;

  // Smallest ratio that still produces a high and a low phase.
  localparam int CLK_DIV_MIN = 2;

  // Widest ratio field any CRG divider uses; callers widen and narrow around the helper.
  localparam int CRG_DIV_MAX_W = 16;

  // Clamp 0/1 up to the minimum ratio. When odd ratios are disabled, also clear
  // the LSB so the output keeps an exact 50% duty cycle. A clamped 2 stays 2.
  function automatic logic [CRG_DIV_MAX_W-1:0] crg_div_sanitize(
    input logic [CRG_DIV_MAX_W-1:0] ratio,
    input logic                     odd_en
  );
    logic [CRG_DIV_MAX_W-1:0] r;
    r = ratio;
    if (r < CRG_DIV_MAX_W'(CLK_DIV_MIN)) begin
      r = CRG_DIV_MAX_W'(CLK_DIV_MIN);
    end
    if (!odd_en) begin
      r[0] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Wrap counter for the clock divider: counts 0..term_i and returns to 0.
// Exposes the next count so the caller can register a glitch-free output
// from it, plus a combinational wrap flag (count currently at term_i).
module clk_div_cnt #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] term_i,
  output logic [WIDTH-1:0] cnt_next_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap;

  // Next count: wrap to 0 at the terminal value, otherwise increment.
  always_comb begin
    wrap  = (cnt_q == term_i);
    cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
  end

  // Count register; reset value is chosen by the parent so the first edge wraps.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next_o = cnt_d;
  assign wrap_o     = wrap;

endmodule

// File: rtl/clk_div.sv
// Programmable integer clock divider with registered, glitch-free output.
// New ratios are accepted over a valid/ready handshake and applied only at a
// period boundary (counter wrap), so clk_o never shows a runt pulse.
// Build option: define CLK_DIV_ODD_EN to honour odd ratios (non-50% duty);
// otherwise accepted ratios are forced even.
module clk_div
  import crg_pkg::*;
#(
  parameter int DIV_WIDTH = 4,
  parameter int DIV_RST   = 2
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic [DIV_WIDTH-1:0] cur_div_o,
  output logic                 clk_o
);

`ifdef CLK_DIV_ODD_EN
  localparam logic ODD_EN = 1'b1;
`else
  localparam logic ODD_EN = 1'b0;
`endif

  localparam logic [DIV_WIDTH-1:0] RST_RATIO = DIV_WIDTH'(DIV_RST);
  localparam logic [DIV_WIDTH-1:0] RST_CNT   = RST_RATIO - DIV_WIDTH'(1);

  clk_div_state_e       state_q, state_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic [DIV_WIDTH-1:0] cur_q, cur_d;
  logic                 clk_q, clk_d;

  logic [DIV_WIDTH-1:0] div_clamped;
  logic [DIV_WIDTH-1:0] cnt_term;
  logic [DIV_WIDTH-1:0] cnt_next;
  logic                 cnt_wrap;

  assign div_clamped = DIV_WIDTH'(crg_div_sanitize(CRG_DIV_MAX_W'(div_i), ODD_EN));
  assign cnt_term    = cur_q - DIV_WIDTH'(1);

  clk_div_cnt #(
    .WIDTH   (DIV_WIDTH),
    .RST_VAL (RST_CNT)
  ) u_cnt (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .term_i     (cnt_term),
    .cnt_next_o (cnt_next),
    .wrap_o     (cnt_wrap)
  );

  // Handshake FSM: capture a sanitised ratio in RUN, swap it in at the next wrap.
  // A wrap on the accepting edge still belongs to the old ratio, because the
  // swap is only considered once the FSM is already in PEND.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cur_d       = cur_q;
    div_ready_o = 1'b0;
    case (state_q)
      RUN: begin
        div_ready_o = 1'b1;
        if (div_valid_i) begin
          pend_d  = div_clamped;
          state_d = PEND;
        end
      end
      PEND: begin
        if (cnt_wrap) begin
          cur_d   = pend_q;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Output phase: high while the upcoming count is inside the high phase.
  // On a wrap the next count is 0, which is high for every legal ratio, so
  // using the current ratio here is equivalent to using the newly applied one.
  always_comb begin
    clk_d = (cnt_next < (cur_q >> 1));
  end

  // State, ratio and output registers; reset discards any pending ratio.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= RUN;
      pend_q  <= RST_RATIO;
      cur_q   <= RST_RATIO;
      clk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
      clk_q   <= clk_d;
    end
  end

  assign cur_div_o = cur_q;
  assign clk_o     = clk_q;

endmodule
